// File: rtl/exe_div_ctrl.sv
// Multi-cycle divide controller for the EXE stage: restoring divider, one quotient bit per cycle,
// handshaking with EXE through req_valid / res_valid / res_ready. Handles div.w, mod.w, div.wu, mod.wu.
module exe_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    input  logic             res_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_acc_q, rem_acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             want_rem_q, want_rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_signed;
    logic [WIDTH-1:0] abs_src1;
    logic [WIDTH-1:0] abs_src2;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        is_signed = req_op[1];
        abs_src1  = (is_signed && src1[WIDTH-1]) ? (~src1 + ONE) : src1;
        abs_src2  = (is_signed && src2[WIDTH-1]) ? (~src2 + ONE) : src2;
    end

    // One restoring step: shift {rem_acc, quo} left, trial-subtract the divisor, keep it if non-negative.
    always_comb begin
        rem_shift = {rem_acc_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {2'b00, dvs_q};
        quo_next  = {quo_q[WIDTH-2:0], 1'b0};
        rem_next  = rem_shift[WIDTH:0];
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end
        q_final = q_neg_q ? (~quo_next + ONE) : quo_next;
        r_final = r_neg_q ? (~rem_next[WIDTH-1:0] + ONE) : rem_next[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_acc_d  = rem_acc_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        want_rem_d = want_rem_q;
        result_d   = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        want_rem_d = req_op[0];
                        if (src2 == '0) begin
                            // Divide-by-zero: quotient is all ones, remainder is the dividend.
                            result_d = req_op[0] ? src1 : '1;
                            state_d  = DONE;
                        end else begin
                            quo_d     = abs_src1;
                            dvs_d     = abs_src2;
                            q_neg_d   = is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                            r_neg_d   = is_signed && src1[WIDTH-1];
                            rem_acc_d = '0;
                            cnt_d     = '0;
                            state_d   = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_acc_d = rem_next;
                    quo_d     = quo_next;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        result_d = want_rem_q ? r_final : q_final;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_acc_q  <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_acc_q  <= rem_acc_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            want_rem_q <= want_rem_d;
            result_q   <= result_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: doc/exe_div_ctrl.md
# exe_div_ctrl

Multi-cycle integer divide controller for the EXE stage. It accepts one div/mod request at a time from EXE, runs a one-bit-per-cycle restoring divider, and stalls EXE through a ready/valid pair. EXE drives `EXE_ready_go` from this block's `res_valid` whenever its instruction is a divide. Covers `div.w`, `mod.w`, `div.wu` and `mod.wu`.

## Interface
- `WIDTH`, default 32: operand and result width. Also sets the iteration count.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EXE holds a valid divide instruction. EXE holds this high, with operands stable, until the result is consumed.
- `req_op` in 2: bit1 = signed, bit0 = return remainder (mod); 0 returns the quotient.
- `src1` in WIDTH: dividend.
- `src2` in WIDTH: divisor.
- `flush` in 1: synchronous cancel, e.g. on exception or ertn.
- `res_ready` in 1: consumer accepts the result. Tied to `MEM_allowin`.
- `busy` out 1: state != IDLE.
- `res_valid` out 1: result available (state == DONE).
- `result` out WIDTH: quotient or remainder, as selected by `req_op[0]`.

## Operation
- States: IDLE, CALC, DONE. Registers: `state`, `cnt` (clog2(WIDTH)+1 bits), `rem_acc` (WIDTH+1), `quo` (WIDTH), `dvs` (WIDTH), `q_neg`, `r_neg`, `want_rem`, `result`.
- IDLE, `req_valid` && !`flush`, `src2` != 0:
  - latch absolute values of `src1` and `src2`; these are the raw values if unsigned;
  - `q_neg` = signed && (src1 MSB ^ src2 MSB); `r_neg` = signed && src1 MSB;
  - `rem_acc` = 0; `cnt` = 0; go to CALC.
- IDLE, `req_valid` && !`flush`, `src2` == 0 (fast path):
  - `result` = all ones if quotient requested, else `src1` unchanged;
  - go directly to DONE.
- CALC, each cycle:
  - shift {`rem_acc`, `quo`} left by 1;
  - trial-subtract `dvs`; if the result is non-negative, keep the difference and set the quotient LSB to 1;
  - `cnt`++.
- CALC, on the WIDTH-th step:
  - apply two's-complement negation per `q_neg`/`r_neg`;
  - register the selected value into `result`; go to DONE.
- DONE: hold `result`. When `res_ready`, go to IDLE.
- Overflow: `0x80000000 / -1` (signed) gives quotient `0x80000000`, remainder 0. This falls out naturally because |src1| = 2^31 fits unsigned; no special case is needed.
- `flush` in any state: next state IDLE, `res_valid` drops next cycle. `flush` has priority over `req_valid` and `res_ready`. No partial result is ever presented.
- Reset (asynchronous, `resetn` = 0): `state` = IDLE, `cnt` = 0, `result` = 0, `busy` = 0, `res_valid` = 0. This applies immediately, including mid-CALC.
- The block does not re-sample `req_valid`/`src*` outside IDLE. Operand changes during CALC are ignored.

## Timing
- Request visible in cycle 0 and latched at the end of cycle 0.
- CALC occupies cycles 1..WIDTH. `res_valid` is high from cycle WIDTH+1. Latency is WIDTH+1 cycles (33 for the default).
- Divide-by-zero: `res_valid` is high in cycle 1 (latency 1).
- Result consumed in the cycle where `res_valid` && `res_ready`: IDLE next cycle. EXE advances in the same cycle, so the earliest next request is sampled one cycle later.
- `res_ready` low in DONE: `res_valid` and `result` stay stable indefinitely.
- Back-to-back divides: one idle cycle between DONE and the next acceptance. Throughput is one divide per WIDTH+2 cycles.
- `busy`, `res_valid` and `result` are all registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned: `div.wu` 100/7 gives `result` = 14 at cycle 33, then `res_ready` = 1; `mod.wu` 100/7 gives 2. `busy` is high in cycles 1..33.
- Signed: `div.w` -7/2 gives `0xFFFFFFFD` (-3); `mod.w` -7/2 gives `0xFFFFFFFF` (-1); `mod.w` 7/-2 gives 1. Overflow case `div.w` `0x80000000`/`0xFFFFFFFF` gives `0x80000000`; `mod.w` of the same gives 0.
- Divide-by-zero: `div.wu` 5/0 gives `0xFFFFFFFF` with `res_valid` in cycle 1; `mod.w` -5/0 gives `0xFFFFFFFB`.
- Backpressure: hold `res_ready` = 0 for 10 cycles after `res_valid`. `result` stays constant and `res_valid` stays high. Release, and the block is in IDLE next cycle. Then issue a back-to-back second request; its result is correct and independent of the first.
- Flush: assert `flush` at cycle 12 of CALC. The block is in IDLE next cycle with `res_valid` = 0. A new request 9/3 then yields 3 with full latency.
- Reset: drop `resetn` mid-CALC and in DONE. All outputs go to 0 immediately (asynchronous, not at the next edge), and the block stays in IDLE after release until `req_valid`.
